// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous memory.
// Writes complete two cycles after acceptance, reads three (one extra cycle for read data).
module mem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0_valid,
   input  logic                  req0_we,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   output logic                  req0_ready,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_rdata,
   input  logic                  req1_valid,
   input  logic                  req1_we,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  req1_ready,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_rdata,
   output logic                  mem_write,
   output logic                  mem_read,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic [DATA_WIDTH-1:0] mem_data_out,
   output logic                  busy
);

   typedef enum logic [1:0] {StIdle, StAccess, StWait} state_e;

   state_e                state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic                  owner_q, owner_d;
   logic                  we_q, we_d;
   logic                  mem_write_q, mem_write_d;
   logic                  mem_read_q, mem_read_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_data_in_q, mem_data_in_d;
   logic [1:0]            rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp0_rdata_q, rsp0_rdata_d;
   logic [DATA_WIDTH-1:0] rsp1_rdata_q, rsp1_rdata_d;

   logic                  grant0, grant1, accept;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   // On a tie the requester that did not win last time gets the grant.
   always_comb begin
      grant0     = req0_valid && (!req1_valid || last_grant_q);
      grant1     = req1_valid && (!req0_valid || !last_grant_q);
      req0_ready = rst_n && (state_q == StIdle) && grant0;
      req1_ready = rst_n && (state_q == StIdle) && grant1;
      accept     = req0_ready || req1_ready;
      sel_we     = req1_ready ? req1_we    : req0_we;
      sel_addr   = req1_ready ? req1_addr  : req0_addr;
      sel_wdata  = req1_ready ? req1_wdata : req0_wdata;
   end

   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      owner_d       = owner_q;
      we_d          = we_q;
      mem_write_d   = 1'b0;
      mem_read_d    = 1'b0;
      mem_addr_d    = mem_addr_q;
      mem_data_in_d = mem_data_in_q;
      rsp_valid_d   = 2'b00;
      rsp0_rdata_d  = rsp0_rdata_q;
      rsp1_rdata_d  = rsp1_rdata_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d      = StAccess;
               last_grant_d = req1_ready;
               owner_d      = req1_ready;
               we_d         = sel_we;
               mem_write_d  = sel_we;
               mem_read_d   = !sel_we;
               mem_addr_d   = sel_addr;
               if (sel_we) begin
                  mem_data_in_d = sel_wdata;
               end
            end
         end
         StAccess: begin
            if (we_q) begin
               state_d              = StIdle;
               rsp_valid_d[owner_q] = 1'b1;
            end else begin
               state_d = StWait;
            end
         end
         StWait: begin
            state_d              = StIdle;
            rsp_valid_d[owner_q] = 1'b1;
            if (owner_q) begin
               rsp1_rdata_d = mem_data_out;
            end else begin
               rsp0_rdata_d = mem_data_out;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         last_grant_q  <= 1'b1;
         owner_q       <= 1'b0;
         we_q          <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_read_q    <= 1'b0;
         mem_addr_q    <= '0;
         mem_data_in_q <= '0;
         rsp_valid_q   <= 2'b00;
         rsp0_rdata_q  <= '0;
         rsp1_rdata_q  <= '0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         owner_q       <= owner_d;
         we_q          <= we_d;
         mem_write_q   <= mem_write_d;
         mem_read_q    <= mem_read_d;
         mem_addr_q    <= mem_addr_d;
         mem_data_in_q <= mem_data_in_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp0_rdata_q  <= rsp0_rdata_d;
         rsp1_rdata_q  <= rsp1_rdata_d;
      end
   end

   assign mem_write   = mem_write_q;
   assign mem_read    = mem_read_q;
   assign mem_addr    = mem_addr_q;
   assign mem_data_in = mem_data_in_q;
   assign rsp0_valid  = rsp_valid_q[0];
   assign rsp1_valid  = rsp_valid_q[1];
   assign rsp0_rdata  = rsp0_rdata_q;
   assign rsp1_rdata  = rsp1_rdata_q;
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: reset/arbitration table, directed corner sequences,
// then random traffic against a transaction-level reference model.
module tb_mem_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   bit         clk_run = 1'b0;
   logic       req0_valid = 0, req0_we = 0, req1_valid = 0, req1_we = 0;
   logic [4:0] req0_addr = 0, req1_addr = 0;
   logic [7:0] req0_wdata = 0, req1_wdata = 0;
   logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
   logic [7:0] rsp0_rdata, rsp1_rdata, mem_data_in;
   logic [7:0] mem_data_out = 8'h00;
   logic       mem_write, mem_read, busy;
   logic [4:0] mem_addr;

   mem_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
      .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
      .rsp1_rdata(rsp1_rdata),
      .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
   );

   initial begin
      forever begin
         #5;
         if (clk_run) clk = ~clk;
      end
   end

   // Memory environment: read data appears the cycle after the read strobe.
   logic [7:0] env_mem [32] = '{default: 8'h00};
   always @(posedge clk) begin
      if (mem_write) env_mem[mem_addr] <= mem_data_in;
      if (mem_read) mem_data_out <= env_mem[mem_addr];
   end

   int passed = 0, total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: one outstanding transaction described by its acceptance cycle.
   int         cyc = 0;
   bit         have_txn = 0, t_we = 0, t_owner = 0, m_last = 1;
   int         t_acc = -10;
   logic [4:0] t_addr = 0;
   logic [7:0] t_data = 0, t_rdata = 0;
   logic [7:0] ref_mem [32] = '{default: 8'h00};
   logic [7:0] exp_rdata0 = 0, exp_rdata1 = 0;
   bit         act_acc0 = 0, act_acc1 = 0, got_rsp0 = 0, got_rsp1 = 0;
   int         grant_log[$];

   task automatic model_check();
      bit b_exp, w_exp, r_exp, s0, s1, idle, e_r0, e_r1;
      int lat;
      if (!rst_n) begin
         have_txn = 0; m_last = 1; exp_rdata0 = 0; exp_rdata1 = 0;
      end
      lat   = t_we ? 2 : 3;
      b_exp = have_txn && cyc > t_acc && cyc < t_acc + lat;
      w_exp = have_txn && t_we && cyc == t_acc + 1;
      r_exp = have_txn && !t_we && cyc == t_acc + 1;
      s0    = have_txn && !t_owner && cyc == t_acc + lat;
      s1    = have_txn && t_owner && cyc == t_acc + lat;
      if (s0 && !t_we) exp_rdata0 = t_rdata;
      if (s1 && !t_we) exp_rdata1 = t_rdata;
      chk("busy", busy, b_exp);
      chk("mem_write", mem_write, w_exp);
      chk("mem_read", mem_read, r_exp);
      chk("strobe_excl", !(mem_read && mem_write), 1);
      if (w_exp || r_exp) chk("mem_addr", mem_addr, t_addr);
      if (w_exp) chk("mem_data_in", mem_data_in, t_data);
      if (!rst_n) begin
         chk("rst_mem_addr", mem_addr, 0);
         chk("rst_mem_data_in", mem_data_in, 0);
      end
      chk("rsp0_valid", rsp0_valid, s0);
      chk("rsp1_valid", rsp1_valid, s1);
      chk("rsp0_rdata", rsp0_rdata, exp_rdata0);
      chk("rsp1_rdata", rsp1_rdata, exp_rdata1);
      if (rsp0_valid === 1'b1) got_rsp0 = 1;
      if (rsp1_valid === 1'b1) got_rsp1 = 1;
      idle = rst_n && !b_exp;
      e_r0 = idle && req0_valid && (!req1_valid || m_last);
      e_r1 = idle && req1_valid && (!req0_valid || !m_last);
      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);
      chk("ready_excl", !(req0_ready && req1_ready), 1);
      act_acc0 = req0_valid && req0_ready;
      act_acc1 = req1_valid && req1_ready;
      if (act_acc0) grant_log.push_back(0);
      if (act_acc1) grant_log.push_back(1);
      if (e_r0 || e_r1) begin
         have_txn = 1; t_acc = cyc; t_owner = e_r1; m_last = e_r1;
         t_we   = e_r1 ? req1_we : req0_we;
         t_addr = e_r1 ? req1_addr : req0_addr;
         t_data = e_r1 ? req1_wdata : req0_wdata;
         if (t_we) ref_mem[t_addr] = t_data;
         else t_rdata = ref_mem[t_addr];
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_check();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // mode: 0 idle, 1 random with occasional withdrawal, 2 always valid
   task automatic drive_rand(input int mode0, input int mode1);
      if (mode0 == 0) req0_valid = 0;
      else if (act_acc0 || !req0_valid) begin
         req0_valid = (mode0 == 2) || ($urandom_range(0, 3) != 0);
         req0_we    = $urandom_range(0, 1) == 1;
         req0_addr  = 5'($urandom_range(0, 7));
         req0_wdata = 8'($urandom);
      end else if (mode0 == 1 && $urandom_range(0, 15) == 0) req0_valid = 0;
      if (mode1 == 0) req1_valid = 0;
      else if (act_acc1 || !req1_valid) begin
         req1_valid = (mode1 == 2) || ($urandom_range(0, 3) != 0);
         req1_we    = $urandom_range(0, 1) == 1;
         req1_addr  = 5'($urandom_range(0, 7));
         req1_wdata = 8'($urandom);
      end else if (mode1 == 1 && $urandom_range(0, 15) == 0) req1_valid = 0;
   endtask

   typedef struct packed {
      logic rst, v0, v1, r0, r1;
   } vec_t;
   vec_t tbl[7];

   initial begin
      bit ok;
      tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

      // Clock held: combinational readiness straight out of reset.
      #1 rst_n = 0;
      #1;
      for (int i = 0; i < 7; i++) begin
         rst_n = tbl[i].rst; req0_valid = tbl[i].v0; req1_valid = tbl[i].v1;
         #1;
         chk($sformatf("tbl%0d_ready0", i), req0_ready, tbl[i].r0);
         chk($sformatf("tbl%0d_ready1", i), req1_ready, tbl[i].r1);
         chk($sformatf("tbl%0d_busy", i), busy, 0);
      end

      rst_n = 0; req0_valid = 0; req1_valid = 0; clk_run = 1;
      step(); step();
      rst_n = 1;
      step();

      // Tie after reset: write from 0 first, then read of the same word by 1.
      req0_valid = 1; req0_we = 1; req0_addr = 5; req0_wdata = 8'hA5;
      req1_valid = 1; req1_we = 0; req1_addr = 5; req1_wdata = 8'h00;
      grant_log.delete(); got_rsp1 = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (act_acc0) req0_valid = 0;
         if (act_acc1) req1_valid = 0;
      end
      chk("r036_grants", grant_log.size(), 2);
      if (grant_log.size() == 2) begin
         chk("r036_first", grant_log[0], 0);
         chk("r036_second", grant_log[1], 1);
      end
      chk("r036_rsp1_seen", got_rsp1, 1);
      chk("r036_rdata", rsp1_rdata, 8'hA5);

      // Both continuously valid: grants must alternate.
      grant_log.delete();
      act_acc0 = 1; act_acc1 = 1;
      drive_rand(2, 2);
      for (int i = 0; i < 100 && grant_log.size() < 8; i++) begin
         step();
         drive_rand(2, 2);
      end
      chk("r037_count", grant_log.size() >= 8, 1);
      for (int i = 1; i < grant_log.size(); i++)
         chk($sformatf("r037_alt%0d", i), grant_log[i] != grant_log[i-1], 1);
      req0_valid = 0; req1_valid = 0;
      for (int i = 0; i < 4; i++) step();

      // Only requester 1: fill and read back every word.
      for (int pass = 0; pass < 2; pass++) begin
         for (int a = 0; a < 32; a++) begin
            req1_valid = 1; req1_we = (pass == 0); req1_addr = 5'(a); req1_wdata = 8'(a);
            ok = 0;
            for (int i = 0; i < 10 && !ok; i++) begin
               step();
               ok = act_acc1;
            end
            chk($sformatf("r038_accept_p%0d_a%0d", pass, a), ok, 1);
            req1_valid = 0;
         end
      end
      for (int i = 0; i < 4; i++) step();
      chk("r038_last_rdata", rsp1_rdata, 8'd31);

      // Reset during ACCESS (k=0) and during WAIT (k=1) of a read.
      for (int k = 0; k < 2; k++) begin
         req0_valid = 1; req0_we = 0; req0_addr = 3; req1_valid = 0;
         ok = 0;
         for (int i = 0; i < 10 && !ok; i++) begin
            step();
            ok = act_acc0;
         end
         chk($sformatf("r039_%0d_accept", k), ok, 1);
         req0_valid = 0;
         if (k == 1) step();
         chk($sformatf("r039_%0d_mem_read_pre", k), mem_read, (k == 0));
         rst_n = 0;
         #1;
         chk($sformatf("r039_%0d_mem_read", k), mem_read, 0);
         chk($sformatf("r039_%0d_busy", k), busy, 0);
         chk($sformatf("r039_%0d_rsp0", k), rsp0_valid, 0);
         step(); step();
         rst_n = 1;
         got_rsp0 = 0;
         for (int i = 0; i < 4; i++) step();
         chk($sformatf("r039_%0d_no_rsp", k), got_rsp0, 0);
      end
      req0_valid = 1; req0_we = 1; req0_addr = 9; req0_wdata = 8'h3C;
      ok = 0;
      for (int i = 0; i < 10 && !ok; i++) begin
         step();
         ok = act_acc0;
      end
      chk("r039_post_accept", ok, 1);
      req0_valid = 0;
      got_rsp0 = 0;
      for (int i = 0; i < 3; i++) step();
      chk("r039_post_rsp", got_rsp0, 1);

      // Random traffic with withdrawals.
      for (int i = 0; i < 1500; i++) begin
         drive_rand(1, 1);
         step();
      end
      req0_valid = 0; req1_valid = 0;
      for (int i = 0; i < 4; i++) step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
